alien_rom_arbiter: RTL and testbench

- Shares one single-port alien sprite ROM among `NREQ` pixel requesters. The ROM is 651 x 8 bit (31 x 21 pixels) with a registered 1-cycle read.
- Uses round-robin arbitration with a registered grant, address mux and a tagged return path.
- Sits between the per-alien draw units and the ROM instance in the VGA (640x480, 25 MHz pixel-enable) pipeline, so several aliens on one scanline fetch from a single block RAM.

---
 rtl/alien_rom_pkg.sv | 9 +
 rtl/alien_rom_arbiter_rr_pick.sv | 28 ++
 rtl/alien_rom_arbiter.sv | 103 ++++++++++
 tb/tb_alien_rom_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alien_rom_pkg.sv
// Shared constants for the alien sprite ROM and its requester arbiter.
package alien_rom_pkg;
  localparam int ALIEN_W     = 31;
  localparam int ALIEN_H     = 21;
  localparam int ALIEN_DEPTH = ALIEN_W * ALIEN_H;  // 651 pixels
  localparam int ALIEN_AW    = 10;
  localparam int PIX_DW      = 8;
  localparam logic [PIX_DW-1:0] PIX_TRANSPARENT = 8'h00;
endpackage

// File: rtl/alien_rom_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after last+1.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_idx,
  output logic            any
);
  // Scan NREQ positions starting one past the previous winner; first hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!any && req[idx]) begin
        any         = 1'b1;
        win_idx     = IDW'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alien_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among NREQ
// requesters, with a tagged 2-cycle return path.
// Optional: define ALIEN_ROM_BOUNDS_CHECK_EN to squash addresses beyond the
// sprite (drive ROM address 0, return transparent pixel).
module alien_rom_arbiter
  import alien_rom_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = ALIEN_AW,
  parameter int DW   = PIX_DW,
  parameter int IDW  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*AW-1:0] i_addr,
  output logic [NREQ-1:0]    o_gnt,
  output logic [AW-1:0]      o_rom_addr,
  input  logic [DW-1:0]      i_rom_data,
  output logic [DW-1:0]      o_data,
  output logic               o_valid,
  output logic [IDW-1:0]     o_id
);
  logic [NREQ-1:0][AW-1:0] addr_v;
  logic [NREQ-1:0]         win_oh;
  logic [IDW-1:0]          win_idx;
  logic                    any;
  logic [IDW-1:0]          last;
  logic [AW-1:0]           win_addr;
  logic [AW-1:0]           rom_addr_d;

  // Stage 0 is the grant itself, stage 1 lines up with ROM data, stage 2 is output.
  logic [2:0]              vld_pipe;
  logic [2:0][IDW-1:0]     id_pipe;

  assign addr_v   = i_addr;
  assign win_addr = addr_v[win_idx];

  rr_priority_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (i_req),
    .last    (last),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

`ifdef ALIEN_ROM_BOUNDS_CHECK_EN
  logic       oob;
  logic [1:0] oob_pipe;

  // Addresses past the sprite still take their slot but read location 0.
  always_comb begin
    oob        = 32'(win_addr) > (ALIEN_DEPTH - 1);
    rom_addr_d = oob ? '0 : win_addr;
  end

  // Carry the out-of-range flag alongside the tag so the pixel can be masked.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) oob_pipe <= '0;
    else       oob_pipe <= {oob_pipe[0], any & oob};

  // Returned pixel: ROM data, or transparent for squashed accesses.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)            o_data <= '0;
    else if (oob_pipe[1]) o_data <= DW'(PIX_TRANSPARENT);
    else                  o_data <= i_rom_data;
`else
  // No bounds check: the winner's address goes straight to the ROM.
  always_comb rom_addr_d = win_addr;

  // Returned pixel is the ROM output, registered.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_data <= '0;
    else       o_data <= i_rom_data;
`endif

  // Grant, ROM address and rotation pointer; idle cycles hold address and pointer.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_gnt      <= '0;
      o_rom_addr <= '0;
      last       <= IDW'(NREQ - 1);
    end else if (any) begin
      o_gnt      <= win_oh;
      o_rom_addr <= rom_addr_d;
      last       <= win_idx;
    end else begin
      o_gnt      <= '0;
    end

  // Tag pipeline: shifts grant valid/ID in step with the ROM read.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], any};
      id_pipe  <= {id_pipe[1:0], win_idx};
    end

  assign o_valid = vld_pipe[2];
  assign o_id    = id_pipe[2];
endmodule

// File: tb/tb_alien_rom_arbiter.sv
// Scoreboard bench for alien_rom_arbiter with a behavioural registered ROM.
module tb_alien_rom_arbiter;
  localparam int NREQ = 4, AW = 10, DW = 8, IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           chk_data;
    logic [31:0]    due;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         i_req = '0;
  logic [NREQ*AW-1:0]      i_addr = '0;
  logic [NREQ-1:0]         o_gnt;
  logic [AW-1:0]           o_rom_addr;
  logic [DW-1:0]           rom_data = '0;
  logic [DW-1:0]           o_data;
  logic                    o_valid;
  logic [IDW-1:0]          o_id;

  logic [NREQ-1:0]         req_r = '0;
  logic [NREQ-1:0][AW-1:0] addr_r = '0;
  logic [AW-1:0]           exp_addr = '0;
  exp_t                    exp_q[$];
  int                      nvec = 0, nerr = 0, cyc = 0;

  alien_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_addr(i_addr),
    .o_gnt(o_gnt), .o_rom_addr(o_rom_addr), .i_rom_data(rom_data),
    .o_data(o_data), .o_valid(o_valid), .o_id(o_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return DW'(32'(a) * 37 + 11);
  endfunction

  // ROM model: 651 entries, 1-cycle registered read; beyond range reads garbage.
  always @(posedge clk)
    rom_data <= (o_rom_addr <= 10'd650) ? rom_val(o_rom_addr) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every o_valid must match the oldest outstanding grant, on time.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL stray_valid: got id %0d with nothing outstanding (t=%0t)", o_id, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ret_id", 32'(o_id), 32'(e.id));
        check("ret_latency", 32'(cyc), e.due);
        if (e.chk_data) check("ret_data", 32'(o_data), 32'(e.data));
      end
    end
  end

  // One cycle: drive requests, then check grant/address and book the return.
  task automatic step(input logic [NREQ-1:0] eg);
    int w;
    exp_t e;
    @(negedge clk);
    i_req = req_r; i_addr = addr_r;
    @(posedge clk); #1;
    check("gnt", 32'(o_gnt), 32'(eg));
    if (eg != '0) begin
      w = 0;
      for (int k = 0; k < NREQ; k++) if (eg[k]) w = k;
      e.id = IDW'(w);
      e.due = 32'(cyc + 2);
      e.chk_data = 1'b1;
      exp_addr = addr_r[w];
      e.data = rom_val(addr_r[w]);
      if (addr_r[w] > 10'd650) begin
`ifdef ALIEN_ROM_BOUNDS_CHECK_EN
        exp_addr = '0;
        e.data = 8'h00;
`else
        e.chk_data = 1'b0;
`endif
      end
      exp_q.push_back(e);
    end
    check("rom_addr", 32'(o_rom_addr), 32'(exp_addr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(o_gnt), 0);
    check({tag, "_rom_addr"}, 32'(o_rom_addr), 0);
    check({tag, "_data"}, 32'(o_data), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_id"}, 32'(o_id), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_r = '0; i_req = '0;
    #1;
    check_all_zero("rst");
    exp_q.delete();
    exp_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] rot [6];
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("init");
    @(negedge clk);
    rst = 1'b0;

    // Single requester, back-to-back at both ends of the sprite.
    req_r = 4'b0100; addr_r[2] = 10'd0;   step(4'b0100);
    addr_r[2] = 10'd650;                  step(4'b0100);
    req_r = '0;                           step('0);
    repeat (3) step('0);

    // Reset with two reads in flight: no return may appear afterwards.
    req_r = 4'b0100; addr_r[2] = 10'd5;   step(4'b0100);
    addr_r[2] = 10'd6;                    step(4'b0100);
    do_reset();
    repeat (4) step('0);

    // Full contention from reset: strict rotation, new address per access.
    req_r = 4'b1111;
    for (int k = 0; k < NREQ; k++) addr_r[k] = AW'(k * 100);
    for (int n = 0; n < 6; n++) begin
      step(rot[n]);
      for (int k = 0; k < NREQ; k++) if (rot[n][k]) addr_r[k] = addr_r[k] + AW'(7);
    end

    // Idle gap: no grants, address held, pipeline drains to no valid.
    req_r = '0;
    for (int n = 0; n < 5; n++) begin
      step('0);
      if (n >= 2) check("idle_valid", 32'(o_valid), 0);
    end

    // Mid-rotation arrival: 1 wins, 0 arrives, then 3, 0, 1.
    req_r = 4'b0001; addr_r[0] = 10'd20;                     step(4'b0001);
    req_r = '0;                                              step('0);
    req_r = 4'b1010; addr_r[1] = 10'd111; addr_r[3] = 10'd333; step(4'b0010);
    req_r = 4'b1011; addr_r[0] = 10'd44;  addr_r[1] = 10'd112; step(4'b1000);
    req_r = 4'b0011;                                         step(4'b0001);
    req_r = 4'b0010;                                         step(4'b0010);
    req_r = '0;
    repeat (3) step('0);

    // Out-of-range address on requester 1.
    req_r = 4'b0010; addr_r[1] = 10'd700; step(4'b0010);
    req_r = '0;
    repeat (4) step('0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
